spi_accel_responder: RTL and testbench

SPI responder that models the Nexys A7 ADXL362 accelerometer as the far end of the SoC's accelerometer SPI master. It is used in simulation and loopback builds in place of the physical sensor. It oversamples the SPI pins in the core clock domain and decodes the ADXL362 write (0x0A) and read (0x0B) commands. It serves a 64-byte register file with auto-incrementing addresses and drives MISO in SPI mode 0.

---
 rtl/spi_accel_responder_if.sv | 26 ++
 rtl/spi_accel_responder.sv | 223 ++++++++++++++++++++++
 tb/tb_spi_accel_responder.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_accel_responder_if.sv
// SPI pin bundle between the accelerometer SPI master and the responder
// model.
//   i_sclk    : SPI clock from the master (mode 0, idles low)
//   i_cs_n    : chip select, active low
//   i_mosi    : master-out data, MSB first
//   o_miso    : responder-out data
//   o_miso_oe : MISO output enable, high only while selected
// The master modport drives the three inputs. The slave modport drives
// MISO and its enable.
interface spi_accel_responder_if;
  logic i_sclk;
  logic i_cs_n;
  logic i_mosi;
  logic o_miso;
  logic o_miso_oe;

  modport master (
    output i_sclk, i_cs_n, i_mosi,
    input  o_miso, o_miso_oe
  );

  modport slave (
    input  i_sclk, i_cs_n, i_mosi,
    output o_miso, o_miso_oe
  );
endinterface

// File: rtl/spi_accel_responder.sv
// ADXL362-style SPI responder used in place of the Nexys A7 accelerometer.
// The SPI pins are oversampled in the core clock domain. The block decodes
// the write (0x0A) and read (0x0B) commands and serves a 64-byte register
// file with auto-incrementing addresses. MISO is driven in SPI mode 0.
//   clk          : core clock (clk_core), rising edge
//   rst          : synchronous active-high reset
//   spi          : SPI pins (slave modport of spi_accel_responder_if)
//   i_x/i_y/i_z  : signed 12-bit samples, latched at chip-select fall
//   o_powerctl   : current contents of register 0x2D
//   o_soft_reset : one-cycle pulse when 0x52 is written to 0x1F
module spi_accel_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  DEVID_AD    = 8'hAD,
  parameter logic [7:0]  DEVID_MST   = 8'h1D,
  parameter logic [7:0]  PARTID      = 8'hF2
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_accel_responder_if.slave spi,
  input  logic signed [11:0]   i_x,
  input  logic signed [11:0]   i_y,
  input  logic signed [11:0]   i_z,
  output logic [7:0]           o_powerctl,
  output logic                 o_soft_reset
);

  localparam logic [7:0] CMD_WRITE      = 8'h0A;
  localparam logic [7:0] CMD_READ       = 8'h0B;
  localparam logic [7:0] SOFT_RESET_KEY = 8'h52;
  localparam logic [5:0] WR_FIRST       = 6'h1F;
  localparam logic [5:0] POWER_CTL      = 6'h2D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync_p0, cs_n_sync_p0, mosi_sync_p0;
  logic                   sclk_p1, cs_n_p1;
  logic                   sclk_s, cs_n_s, mosi_s;
  logic                   rise_sclk, fall_sclk, cs_fall, cs_rise;

  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
  logic [7:0]             rx_byte;
  logic [7:0]             tx_byte;
  logic [5:0]             addr;
  logic                   is_read;
  logic                   miso_q;
  logic                   oe_q;
  logic                   soft_rst_q;
  logic signed [11:0]     x_snap, y_snap, z_snap;
  logic [7:0]             wr_mem [31:63];

  logic                   bit_en, rx_en, byte_done, wr_commit, rd_fall;

  // Stage p0: synchronizer chains. They are not reset, so a chip select
  // that is still low when rst is released does not look like a new
  // falling edge.
  always_ff @(posedge clk) begin
    sclk_sync_p0 <= {sclk_sync_p0[SYNC_STAGES-2:0], spi.i_sclk};
    cs_n_sync_p0 <= {cs_n_sync_p0[SYNC_STAGES-2:0], spi.i_cs_n};
    mosi_sync_p0 <= {mosi_sync_p0[SYNC_STAGES-2:0], spi.i_mosi};
  end

  assign sclk_s = sclk_sync_p0[SYNC_STAGES-1];
  assign cs_n_s = cs_n_sync_p0[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_p0[SYNC_STAGES-1];

  // Stage p1: previous synchronized sample for edge detection.
  always_ff @(posedge clk) begin
    sclk_p1 <= sclk_s;
    cs_n_p1 <= cs_n_s;
  end

  assign rise_sclk = sclk_s & ~sclk_p1;
  assign fall_sclk = ~sclk_s & sclk_p1;
  assign cs_fall   = ~cs_n_s & cs_n_p1;
  assign cs_rise   = cs_n_s & ~cs_n_p1;

  // The incoming byte includes the bit being sampled on this rising edge.
  assign rx_byte = {shreg[6:0], mosi_s};

  function automatic logic [7:0] reg_read(input logic [5:0] a);
    logic [7:0] v;
    v = 8'h00;
    case (a)
      6'h00:   v = DEVID_AD;
      6'h01:   v = DEVID_MST;
      6'h02:   v = PARTID;
      6'h08:   v = x_snap[11:4];
      6'h09:   v = y_snap[11:4];
      6'h0A:   v = z_snap[11:4];
      6'h0E:   v = x_snap[7:0];
      6'h0F:   v = {{4{x_snap[11]}}, x_snap[11:8]};
      6'h10:   v = y_snap[7:0];
      6'h11:   v = {{4{y_snap[11]}}, y_snap[11:8]};
      6'h12:   v = z_snap[7:0];
      6'h13:   v = {{4{z_snap[11]}}, z_snap[11:8]};
      default: if (a >= WR_FIRST) v = wr_mem[a];
    endcase
    return v;
  endfunction

  assign tx_byte = reg_read(addr);

  // Stage p2: FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cs_rise) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (cs_fall) state_nxt = ST_CMD;
        ST_CMD: begin
          if (byte_done)
            state_nxt = (rx_byte == CMD_WRITE || rx_byte == CMD_READ) ? ST_ADDR : ST_IGNORE;
        end
        ST_ADDR: if (byte_done) state_nxt = ST_DATA;
        default: ;
      endcase
    end
  end

  // Control strobes. During a read, the shift register holds outgoing
  // data, so MOSI bits are not shifted into it.
  always_comb begin
    bit_en    = 1'b0;
    rx_en     = 1'b0;
    rd_fall   = 1'b0;
    case (state)
      ST_CMD, ST_ADDR: begin
        bit_en = rise_sclk;
        rx_en  = rise_sclk;
      end
      ST_DATA: begin
        bit_en  = rise_sclk;
        rx_en   = rise_sclk & ~is_read;
        rd_fall = fall_sclk & is_read;
      end
      default: ;
    endcase
    byte_done = bit_en & (bit_cnt == 3'd7);
    wr_commit = byte_done & (state == ST_DATA) & ~is_read;
  end

  // Stage p2: datapath registers, updated one clock after the event.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      addr       <= 6'h00;
      is_read    <= 1'b0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      soft_rst_q <= 1'b0;
      x_snap     <= '0;
      y_snap     <= '0;
      z_snap     <= '0;
      for (int i = 31; i < 64; i++) wr_mem[i] <= 8'h00;
    end else begin
      soft_rst_q <= 1'b0;

      if (cs_fall) begin
        oe_q    <= 1'b1;
        bit_cnt <= 3'd0;
        x_snap  <= i_x;
        y_snap  <= i_y;
        z_snap  <= i_z;
      end else if (bit_en) begin
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (cs_rise) oe_q <= 1'b0;

      if (rx_en) shreg <= rx_byte;

      if (state == ST_CMD && byte_done) is_read <= (rx_byte == CMD_READ);

      if (state == ST_ADDR && byte_done)      addr <= rx_byte[5:0];
      else if (state == ST_DATA && byte_done) addr <= addr + 6'd1;

      if (wr_commit) begin
        if (addr == WR_FIRST && rx_byte == SOFT_RESET_KEY) begin
          for (int i = 31; i < 64; i++) wr_mem[i] <= 8'h00;
          soft_rst_q <= 1'b1;
        end else if (addr >= WR_FIRST) begin
          wr_mem[addr] <= rx_byte;
        end
      end

      // At a byte boundary (bit_cnt == 0), load a fresh register and present
      // its MSB. Otherwise, shift out the next bit.
      if (rd_fall) begin
        if (bit_cnt == 3'd0) begin
          miso_q <= tx_byte[7];
          shreg  <= {tx_byte[6:0], 1'b0};
        end else begin
          miso_q <= shreg[7];
          shreg  <= {shreg[6:0], 1'b0};
        end
      end

      if (cs_rise || state != ST_DATA || !is_read) miso_q <= 1'b0;
    end
  end

  assign spi.o_miso    = miso_q;
  assign spi.o_miso_oe = oe_q;
  assign o_powerctl    = wr_mem[POWER_CTL];
  assign o_soft_reset  = soft_rst_q;

endmodule

// File: tb/tb_spi_accel_responder.sv
// Testbench for spi_accel_responder. A task-driven SPI master issues
// directed and random transactions. A register-map reference model
// predicts read data. A bus monitor compares each completed MISO byte
// against the expectation queue.
module tb_spi_accel_responder;
  localparam int SYNC = 2;
  localparam int HALF = 4;

  logic clk = 1'b0;
  logic rst;
  logic signed [11:0] x, y, z;
  logic [7:0] powerctl;
  logic soft_reset;

  spi_accel_responder_if spi_if ();

  spi_accel_responder #(
    .SYNC_STAGES(SYNC),
    .DEVID_AD   (8'hAD),
    .DEVID_MST  (8'h1D),
    .PARTID     (8'hF2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .spi         (spi_if),
    .i_x         (x),
    .i_y         (y),
    .i_z         (z),
    .o_powerctl  (powerctl),
    .o_soft_reset(soft_reset)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model
  logic [7:0]         m_mem [0:63];
  logic signed [11:0] m_x, m_y, m_z;
  int                 m_sr_pulses = 0;
  int                 sr_seen = 0;
  logic [7:0]         exp_q [$];
  logic [7:0]         tx_q [$];

  function automatic int sample_of(input int k);
    if (k == 0) return int'(m_x);
    if (k == 1) return int'(m_y);
    return int'(m_z);
  endfunction

  function automatic logic [7:0] model_read(input int a);
    int v;
    if (a == 0) return 8'hAD;
    if (a == 1) return 8'h1D;
    if (a == 2) return 8'hF2;
    if (a >= 8 && a <= 10) begin
      v = sample_of(a - 8);
      return 8'((v >>> 4) & 255);
    end
    if (a >= 14 && a <= 19) begin
      v = sample_of((a - 14) / 2);
      if (a % 2 == 0) return 8'(v & 255);
      return 8'((v >> 8) & 255);
    end
    if (a >= 31) return m_mem[a];
    return 8'h00;
  endfunction

  task automatic model_clear();
    for (int j = 0; j < 64; j++) m_mem[j] = 8'h00;
  endtask

  task automatic model_write(input int nbits);
    int a;
    if (tx_q[0] == 8'h0A && nbits >= 16) begin
      a = int'(tx_q[1]) % 64;
      for (int i = 2; i < nbits / 8; i++) begin
        if (a == 31 && tx_q[i] == 8'h52) begin
          for (int j = 31; j < 64; j++) m_mem[j] = 8'h00;
          m_sr_pulses++;
        end else if (a >= 31) begin
          m_mem[a] = tx_q[i];
        end
        a = (a + 1) % 64;
      end
    end
  endtask

  task automatic model_expect_reads(input int nbits);
    int a;
    if (tx_q[0] == 8'h0B && nbits >= 16) begin
      a = int'(tx_q[1]) % 64;
      for (int i = 2; i < nbits / 8; i++) begin
        exp_q.push_back(model_read(a));
        a = (a + 1) % 64;
      end
    end
  endtask

  always @(negedge clk) if (soft_reset === 1'b1) sr_seen++;

  // Bus monitor: reassembles each SPI byte as a mode-0 master would.
  int         mon_bits = 0;
  int         mon_byte = 0;
  logic [7:0] mon_mosi, mon_miso, mon_cmd, mon_exp;
  bit         mon_ignore = 1'b0;

  always @(spi_if.i_cs_n or posedge spi_if.i_sclk) begin
    if (spi_if.i_cs_n) begin
      mon_bits = 0;
      mon_byte = 0;
    end else if (spi_if.i_sclk && !mon_ignore) begin
      mon_mosi = {mon_mosi[6:0], spi_if.i_mosi};
      mon_miso = {mon_miso[6:0], spi_if.o_miso};
      mon_bits++;
      if (mon_bits == 8) begin
        mon_bits = 0;
        if (mon_byte == 0) mon_cmd = mon_mosi;
        if (mon_cmd == 8'h0B && mon_byte >= 2) begin
          if (exp_q.size() == 0) begin
            check("read_byte_unexpected", 1, 0);
          end else begin
            mon_exp = exp_q.pop_front();
            check("read_byte", mon_miso, mon_exp);
          end
        end else begin
          check("miso_quiet_byte", mon_miso, 0);
        end
        mon_byte++;
      end
    end
  end

  // SPI master
  int         probe_bit = -1;
  logic [7:0] probe_old, probe_new;

  task automatic spi_xfer(input int nbits, input int scramble);
    logic [7:0] cur;
    @(negedge clk);
    spi_if.i_sclk = 1'b0;
    spi_if.i_cs_n = 1'b0;
    cur = tx_q[0];
    spi_if.i_mosi = cur[7];
    repeat (HALF) @(negedge clk);
    check("miso_oe_selected", spi_if.o_miso_oe, 1);
    for (int b = 0; b < nbits; b++) begin
      spi_if.i_sclk = 1'b1;
      for (int k = 0; k < HALF; k++) begin
        @(negedge clk);
        if (b == probe_bit && k == 1) check("powerctl_before_commit", powerctl, probe_old);
        if (b == probe_bit && k == 2) check("powerctl_at_commit", powerctl, probe_new);
      end
      spi_if.i_sclk = 1'b0;
      if (b == nbits / 2) begin
        if (scramble == 1) x = 12'h000;
        if (scramble == 2) begin
          x = 12'($urandom_range(4095, 0));
          y = 12'($urandom_range(4095, 0));
          z = 12'($urandom_range(4095, 0));
        end
      end
      if (b + 1 < nbits) begin
        cur = tx_q[(b + 1) / 8];
        spi_if.i_mosi = cur[7 - ((b + 1) % 8)];
      end
      repeat (HALF) @(negedge clk);
    end
    spi_if.i_cs_n = 1'b1;
  endtask

  task automatic transact(input int nbits, input int scramble);
    m_x = x;
    m_y = y;
    m_z = z;
    model_expect_reads(nbits);
    spi_xfer(nbits, scramble);
    model_write(nbits);
    repeat (10) @(negedge clk);
    check("powerctl", powerctl, m_mem[45]);
    check("soft_reset_pulses", sr_seen, m_sr_pulses);
    check("miso_oe_deselected", spi_if.o_miso_oe, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, len, a, nb;
    rst = 1'b1;
    spi_if.i_cs_n = 1'b1;
    spi_if.i_sclk = 1'b0;
    spi_if.i_mosi = 1'b0;
    x = '0;
    y = '0;
    z = '0;
    model_clear();
    repeat (6) @(negedge clk);
    check("reset_miso", spi_if.o_miso, 0);
    check("reset_miso_oe", spi_if.o_miso_oe, 0);
    check("reset_powerctl", powerctl, 0);
    check("reset_soft_reset", soft_reset, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // ID registers
    tx_q = {8'h0B, 8'h00, 8'h00, 8'h00, 8'h00};
    transact(40, 0);

    // POWER_CTL write with commit timing, then readback
    tx_q = {8'h0A, 8'h2D, 8'h02};
    probe_bit = 23;
    probe_old = m_mem[45];
    probe_new = 8'h02;
    transact(24, 0);
    probe_bit = -1;
    tx_q = {8'h0B, 8'h2D, 8'h00};
    transact(24, 0);

    // Coherent burst over sample registers while x changes mid-transaction
    x = 12'h9AB;
    y = 12'h123;
    z = 12'h7FF;
    tx_q = {8'h0B, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    transact(64, 1);
    tx_q = {8'h0A, 8'h3F, 8'h5A};
    transact(24, 0);
    tx_q = {8'h0B, 8'h3F, 8'h00, 8'h00};
    transact(32, 0);

    // Aborted write data byte, then a normal read
    tx_q = {8'h0A, 8'h20, 8'hA5};
    transact(21, 0);
    tx_q = {8'h0B, 8'h20, 8'h00};
    transact(24, 0);

    // Soft reset followed by continuation at 0x20; read-only write
    tx_q = {8'h0A, 8'h2D, 8'h02};
    transact(24, 0);
    tx_q = {8'h0A, 8'h1F, 8'h52, 8'h77};
    transact(32, 0);
    tx_q = {8'h0B, 8'h1F, 8'h00, 8'h00};
    transact(32, 0);
    tx_q = {8'h0A, 8'h00, 8'h55};
    transact(24, 0);
    tx_q = {8'h0B, 8'h00, 8'h00};
    transact(24, 0);

    // Invalid command with two trailing bytes
    tx_q = {8'h0D, 8'h2D, 8'hFF};
    transact(24, 0);
    tx_q = {8'h0B, 8'h2D, 8'h00};
    transact(24, 0);

    // rst during a read
    tx_q = {8'h0A, 8'h2D, 8'h03};
    transact(24, 0);
    mon_ignore = 1'b1;
    tx_q = {8'h0B, 8'h30, 8'h00, 8'h00};
    fork
      spi_xfer(32, 0);
      begin
        repeat (150) @(negedge clk);
        check("oe_before_rst", spi_if.o_miso_oe, 1);
        rst = 1'b1;
        @(negedge clk);
        check("oe_after_rst", spi_if.o_miso_oe, 0);
        check("miso_after_rst", spi_if.o_miso, 0);
        rst = 1'b0;
      end
    join
    model_clear();
    repeat (10) @(negedge clk);
    mon_ignore = 1'b0;
    check("powerctl_after_rst", powerctl, 0);
    tx_q = {8'h0B, 8'h2D, 8'h00};
    transact(24, 0);

    // Random transactions
    for (int t = 0; t < 40; t++) begin
      x = 12'($urandom_range(4095, 0));
      y = 12'($urandom_range(4095, 0));
      z = 12'($urandom_range(4095, 0));
      kind = $urandom_range(0, 3);
      len = $urandom_range(1, 4);
      a = (kind == 0 && $urandom_range(0, 1) == 1) ? $urandom_range(31, 63) : $urandom_range(0, 63);
      tx_q.delete();
      if (kind == 2) begin
        tx_q.push_back(8'($urandom_range(12, 255)));
      end else if (kind == 0 || (kind == 3 && $urandom_range(0, 1) == 1)) begin
        tx_q.push_back(8'h0A);
      end else begin
        tx_q.push_back(8'h0B);
      end
      tx_q.push_back(8'(a));
      for (int i = 0; i < len; i++) begin
        if (tx_q[0] == 8'h0A) tx_q.push_back(8'($urandom_range(0, 255)));
        else tx_q.push_back(8'h00);
      end
      nb = 8 * (2 + len);
      if (kind == 3) nb = nb - $urandom_range(1, 7);
      transact(nb, ($urandom_range(0, 1) == 1) ? 2 : 0);
    end

    repeat (20) @(negedge clk);
    check("expectations_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
